// File: rtl/plic_pkg.sv
// Shared constants and helpers for the PLIC target array and its priority selector.
package plic_pkg;

    localparam int ID_NONE = 0;

    localparam int DEF_SOURCES       = 8;
    localparam int DEF_TARGETS       = 2;
    localparam int DEF_PRIORITY_BITS = 3;
    localparam int DEF_ID_BITS       = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Minimum ID width able to encode 0 plus every source ID.
    function automatic int min_id_bits(input int sources);
        return clog2(sources + 1);
    endfunction

endpackage

// File: rtl/plic_priority_select.sv
// Combinational max-priority selector: returns the highest-priority candidate,
// lowest ID on a tie, or ID 0 / priority 0 when no candidate is present.
module plic_priority_select
    import plic_pkg::*;
#(
    parameter int SOURCES       = DEF_SOURCES,
    parameter int PRIORITY_BITS = DEF_PRIORITY_BITS,
    parameter int ID_BITS       = DEF_ID_BITS
) (
    input  logic [SOURCES-1:0]               cand_i,
    input  logic [SOURCES*PRIORITY_BITS-1:0] prio_i,
    output logic [ID_BITS-1:0]               id_o,
    output logic [PRIORITY_BITS-1:0]         pr_o
);

    // Ascending scan with strict compare keeps the lowest ID on equal priority.
    always_comb begin
        id_o = ID_BITS'(ID_NONE);
        pr_o = '0;
        for (int s = 0; s < SOURCES; s++) begin
            if (cand_i[s] && (prio_i[s*PRIORITY_BITS +: PRIORITY_BITS] > pr_o)) begin
                id_o = ID_BITS'(s + 1);
                pr_o = prio_i[s*PRIORITY_BITS +: PRIORITY_BITS];
            end
        end
    end

endmodule

// File: rtl/plic_target_array.sv
// Multi-target PLIC back end: per-target selection and threshold compare, plus the
// claim/complete handshake around a global in-flight (busy) mask.
module plic_target_array
    import plic_pkg::*;
#(
    parameter int SOURCES       = DEF_SOURCES,
    parameter int TARGETS       = DEF_TARGETS,
    parameter int PRIORITY_BITS = DEF_PRIORITY_BITS,
    parameter int ID_BITS       = DEF_ID_BITS
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [SOURCES-1:0]                 src_pending_i,
    input  logic [SOURCES*PRIORITY_BITS-1:0]   src_priority_i,
    input  logic [TARGETS*SOURCES-1:0]         enable_i,
    input  logic [TARGETS*PRIORITY_BITS-1:0]   threshold_i,
    input  logic [TARGETS-1:0]                 claim_i,
    input  logic [TARGETS-1:0]                 complete_i,
    input  logic [TARGETS*ID_BITS-1:0]         complete_id_i,
    output logic [TARGETS-1:0]                 ireq_o,
    output logic [TARGETS*ID_BITS-1:0]         id_o,
    output logic [TARGETS-1:0]                 claim_valid_o,
    output logic [TARGETS*ID_BITS-1:0]         claim_id_o,
    output logic [SOURCES-1:0]                 src_claimed_o
);

    logic [SOURCES-1:0]               busy_q, busy_d;
    logic [SOURCES-1:0]               prio_nz;
    logic [SOURCES-1:0]               claim_mask, complete_mask;
    logic [TARGETS*ID_BITS-1:0]       id_q, id_d;
    logic [TARGETS*PRIORITY_BITS-1:0] sel_pr;
    logic [TARGETS-1:0]               ireq_q, ireq_d;
    logic [TARGETS-1:0]               claim_valid_q;
    logic [TARGETS*ID_BITS-1:0]       claim_id_q, claim_id_d;
    logic [SOURCES-1:0]               src_claimed_q;

    always_comb begin
        prio_nz = '0;
        for (int s = 0; s < SOURCES; s++) begin
            prio_nz[s] = |src_priority_i[s*PRIORITY_BITS +: PRIORITY_BITS];
        end
    end

    for (genvar t = 0; t < TARGETS; t++) begin : g_target
        plic_priority_select #(
            .SOURCES       (SOURCES),
            .PRIORITY_BITS (PRIORITY_BITS),
            .ID_BITS       (ID_BITS)
        ) u_select (
            .cand_i (src_pending_i & ~busy_q & enable_i[t*SOURCES +: SOURCES] & prio_nz),
            .prio_i (src_priority_i),
            .id_o   (id_d[t*ID_BITS +: ID_BITS]),
            .pr_o   (sel_pr[t*PRIORITY_BITS +: PRIORITY_BITS])
        );

        assign ireq_d[t] = sel_pr[t*PRIORITY_BITS +: PRIORITY_BITS] >
                           threshold_i[t*PRIORITY_BITS +: PRIORITY_BITS];
    end

    // Claims grant the registered ID; busy and lower-index targets shadow it, which
    // closes the window where id_q still shows a source claimed the cycle before.
    always_comb begin
        claim_mask = '0;
        claim_id_d = '0;
        for (int t = 0; t < TARGETS; t++) begin
            for (int s = 0; s < SOURCES; s++) begin
                if (claim_i[t] && (id_q[t*ID_BITS +: ID_BITS] == ID_BITS'(s + 1)) &&
                    !busy_q[s] && !claim_mask[s]) begin
                    claim_mask[s]                  = 1'b1;
                    claim_id_d[t*ID_BITS +: ID_BITS] = ID_BITS'(s + 1);
                end
            end
        end
    end

    // Only IDs 1..SOURCES can match, so out-of-range codes fall through as ignored.
    always_comb begin
        complete_mask = '0;
        for (int t = 0; t < TARGETS; t++) begin
            for (int s = 0; s < SOURCES; s++) begin
                if (complete_i[t] && (complete_id_i[t*ID_BITS +: ID_BITS] == ID_BITS'(s + 1)) &&
                    busy_q[s] && enable_i[t*SOURCES + s]) begin
                    complete_mask[s] = 1'b1;
                end
            end
        end
    end

    assign busy_d = (busy_q & ~complete_mask) | claim_mask;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q        <= '0;
            id_q          <= '0;
            ireq_q        <= '0;
            claim_valid_q <= '0;
            claim_id_q    <= '0;
            src_claimed_q <= '0;
        end else begin
            busy_q        <= busy_d;
            id_q          <= id_d;
            ireq_q        <= ireq_d;
            claim_valid_q <= claim_i;
            claim_id_q    <= claim_id_d;
            src_claimed_q <= claim_mask;
        end
    end

    assign ireq_o        = ireq_q;
    assign id_o          = id_q;
    assign claim_valid_o = claim_valid_q;
    assign claim_id_o    = claim_id_q;
    assign src_claimed_o = src_claimed_q;

endmodule
